decoder_i_ld_index_imm_seq: RTL and testbench

//  Sequencer for LD <index>,nn with NUM_IDX index registers and an IMM_BYTES immediate.

---
 rtl/decoder_i_ld_index_imm_seq_pkg.sv | 19 +
 rtl/decoder_onehot_n.sv | 20 ++
 rtl/decoder_i_ld_index_imm_seq.sv | 119 +++++++++++
 tb/tb_decoder_i_ld_index_imm_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_i_ld_index_imm_seq_pkg.sv
// Shared state encoding and width helpers for the LD <index>,nn sequencer.
package decoder_i_ld_index_imm_seq_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFetch  = 2'd1,
    StFinish = 2'd2
  } state_t;

  // Width of a binary index-select field; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned lane_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/decoder_onehot_n.sv
// Binary select to N-wide one-hot with enable; out-of-range selects give all zeros.
module decoder_onehot_n #(
  parameter int unsigned NumOut = 2,
  parameter int unsigned SelW   = 1
) (
  input  logic              i_en,
  input  logic [SelW-1:0]   i_sel,
  output logic [NumOut-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int unsigned i = 0; i < NumOut; i++) begin
      if (i_en && (i_sel == SelW'(i))) begin
        o_onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_i_ld_index_imm_seq.sv
// LD <index>,nn sequencer: latches the index select, fetches IMM_BYTES operand bytes and
// issues one byte-write strobe per byte, then pulses the instruction-end controls.
module decoder_i_ld_index_imm_seq
  import decoder_i_ld_index_imm_seq_pkg::*;
#(
  parameter int unsigned NUM_IDX    = 2,
  parameter int unsigned IMM_BYTES  = 2,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned IDX_LSB    = 2,
  parameter bit          HIGH_FIRST = 1'b0,
  localparam int unsigned IDX_W     = idx_w(NUM_IDX),
  localparam int unsigned LANE_W    = lane_w(IMM_BYTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [7:0]        ITABLE,
  input  logic              opd_valid,
  input  logic [DATA_W-1:0] opd_data,
  output logic              opd_ready,
  output logic              Pa_Ophd,
  output logic [NUM_IDX-1:0] PR_Write_idx,
  output logic [LANE_W-1:0] PR_Write_lane,
  output logic [DATA_W-1:0] PR_Write_data,
  output logic              PR_Reset_XPT,
  output logic              PR_InvertIn,
  output logic              P2_Set_CM1,
  output logic              P2_Reset_ITABLE,
  output logic              busy,
  output logic              err_idx
);

  localparam logic [IDX_W:0]    NumIdxCmp = (IDX_W + 1)'(NUM_IDX);
  localparam logic [LANE_W-1:0] LastCnt   = LANE_W'(IMM_BYTES - 1);

  state_t              r_state, w_state_d;
  logic [IDX_W-1:0]    r_sel;
  logic [LANE_W-1:0]   r_cnt;
  logic                r_wr_en;
  logic [LANE_W-1:0]   r_wr_lane;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_start;
  logic                r_err;

  logic [IDX_W-1:0]    w_sel_field;
  logic                w_sel_bad;
  logic                w_start;
  logic                w_accept;
  logic                w_last;
  logic [LANE_W-1:0]   w_lane;
  logic                w_unused_itable;

  assign w_sel_field     = ITABLE[IDX_LSB +: IDX_W];
  assign w_sel_bad       = ({1'b0, w_sel_field} >= NumIdxCmp);
  assign w_start         = (r_state == StIdle) && enable;
  assign w_accept        = opd_valid && opd_ready;
  assign w_last          = (r_cnt == LastCnt);
  assign w_lane          = HIGH_FIRST ? (LastCnt - r_cnt) : r_cnt;
  assign w_unused_itable = ^ITABLE;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (enable) w_state_d = w_sel_bad ? StFinish : StFetch;
      StFetch:  if (w_accept && w_last) w_state_d = StFinish;
      StFinish: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_lane <= '0;
      r_wr_data <= '0;
      r_start   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_start <= w_start;
      r_wr_en <= w_accept;
      if (w_start) begin
        r_sel <= w_sel_field;
        if (w_sel_bad) r_err <= 1'b1;
      end
      if (w_accept) begin
        r_wr_lane <= w_lane;
        r_wr_data <= opd_data;
        r_cnt     <= r_cnt + LANE_W'(1);
      end
      if (r_state == StFinish) r_cnt <= '0;
    end
  end

  // A bad select never reaches FETCH, so the strobe enable alone gates writes.
  decoder_onehot_n #(
    .NumOut(NUM_IDX),
    .SelW  (IDX_W)
  ) u_onehot (
    .i_en    (r_wr_en),
    .i_sel   (r_sel),
    .o_onehot(PR_Write_idx)
  );

  assign opd_ready       = (r_state == StFetch);
  assign Pa_Ophd         = (r_state == StFetch);
  assign busy            = (r_state != StIdle);
  assign P2_Set_CM1      = (r_state == StFinish);
  assign P2_Reset_ITABLE = (r_state == StFinish);
  assign PR_Reset_XPT    = r_start;
  assign PR_InvertIn     = r_start;
  assign PR_Write_lane   = r_wr_lane;
  assign PR_Write_data   = r_wr_data;
  assign err_idx         = r_err;

endmodule

// File: tb/tb_decoder_i_ld_index_imm_seq.sv
// Scoreboard bench: two sequencer instances (default and 3-index/3-byte high-first).
module tb_decoder_i_ld_index_imm_seq;

  typedef struct packed {
    logic [3:0] idx;
    logic [3:0] lane;
    logic [7:0] data;
  } wr_t;

  logic clk;
  int   checks   = 0;
  int   failures = 0;

  wr_t wq0[$];
  wr_t wq1[$];
  int  eq0[$];
  int  eq1[$];

  // Instance A: defaults
  logic       a_reset, a_en, a_valid, a_ready, a_ophd, a_xpt, a_inv, a_cm1, a_rit, a_busy, a_err;
  logic [7:0] a_itable, a_data, a_wr_data;
  logic [1:0] a_wr_idx;
  logic [0:0] a_wr_lane;

  // Instance B: NUM_IDX=3, IMM_BYTES=3, HIGH_FIRST=1
  logic       b_reset, b_en, b_valid, b_ready, b_ophd, b_xpt, b_inv, b_cm1, b_rit, b_busy, b_err;
  logic [7:0] b_itable, b_data, b_wr_data;
  logic [2:0] b_wr_idx;
  logic [1:0] b_wr_lane;

  decoder_i_ld_index_imm_seq u_dut_a (
    .clk(clk), .reset(a_reset), .enable(a_en), .ITABLE(a_itable),
    .opd_valid(a_valid), .opd_data(a_data), .opd_ready(a_ready), .Pa_Ophd(a_ophd),
    .PR_Write_idx(a_wr_idx), .PR_Write_lane(a_wr_lane), .PR_Write_data(a_wr_data),
    .PR_Reset_XPT(a_xpt), .PR_InvertIn(a_inv), .P2_Set_CM1(a_cm1),
    .P2_Reset_ITABLE(a_rit), .busy(a_busy), .err_idx(a_err)
  );

  decoder_i_ld_index_imm_seq #(
    .NUM_IDX(3), .IMM_BYTES(3), .DATA_W(8), .IDX_LSB(2), .HIGH_FIRST(1'b1)
  ) u_dut_b (
    .clk(clk), .reset(b_reset), .enable(b_en), .ITABLE(b_itable),
    .opd_valid(b_valid), .opd_data(b_data), .opd_ready(b_ready), .Pa_Ophd(b_ophd),
    .PR_Write_idx(b_wr_idx), .PR_Write_lane(b_wr_lane), .PR_Write_data(b_wr_data),
    .PR_Reset_XPT(b_xpt), .PR_InvertIn(b_inv), .P2_Set_CM1(b_cm1),
    .P2_Reset_ITABLE(b_rit), .busy(b_busy), .err_idx(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: every strobe and end pulse must match the next queued expectation.
  always @(negedge clk) begin : mon_a
    wr_t e;
    int  ee;
    if (a_wr_idx != 2'b00) begin
      if (wq0.size() == 0) chk("a_extra_write", int'(a_wr_idx), 0);
      else begin
        e = wq0.pop_front();
        chk("a_wr_idx", int'(a_wr_idx), int'(e.idx));
        chk("a_wr_lane", int'(a_wr_lane), int'(e.lane));
        chk("a_wr_data", int'(a_wr_data), int'(e.data));
      end
    end
    if (a_cm1 || a_rit) begin
      if (eq0.size() == 0) chk("a_extra_end", int'({a_cm1, a_rit}), 0);
      else begin
        ee = eq0.pop_front();
        chk("a_end_pulse", int'({a_cm1, a_rit}), 3);
        chk("a_err_at_end", int'(a_err), ee);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    wr_t e;
    int  ee;
    if (b_wr_idx != 3'b000) begin
      if (wq1.size() == 0) chk("b_extra_write", int'(b_wr_idx), 0);
      else begin
        e = wq1.pop_front();
        chk("b_wr_idx", int'(b_wr_idx), int'(e.idx));
        chk("b_wr_lane", int'(b_wr_lane), int'(e.lane));
        chk("b_wr_data", int'(b_wr_data), int'(e.data));
      end
    end
    if (b_cm1 || b_rit) begin
      if (eq1.size() == 0) chk("b_extra_end", int'({b_cm1, b_rit}), 0);
      else begin
        ee = eq1.pop_front();
        chk("b_end_pulse", int'({b_cm1, b_rit}), 3);
        chk("b_err_at_end", int'(b_err), ee);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two-byte sequence on A with 'gap' idle cycles before each byte; optional held enable.
  task automatic run_a(input logic [7:0] it, input logic [7:0] b0, input logic [7:0] b1,
                       input int gap, input int sel, input bit hold);
    int lat;
    lat = -1;
    wq0.push_back('{idx: 4'(1 << sel), lane: 4'd0, data: b0});
    wq0.push_back('{idx: 4'(1 << sel), lane: 4'd1, data: b1});
    eq0.push_back(0);
    a_itable = it;
    a_en     = 1'b1;
    for (int t = 1; t <= 2 * gap + 8; t++) begin
      step();
      if (a_cm1 && lat < 0) lat = t;
      if (t == 1) begin
        chk("a_xpt_pulse", int'(a_xpt), 1);
        chk("a_inv_pulse", int'(a_inv), 1);
      end
      if (t == 2) chk("a_xpt_single", int'(a_xpt), 0);
      if (t <= 2 * gap + 2) begin
        chk("a_ophd_fetch", int'(a_ophd), 1);
        chk("a_ready_fetch", int'(a_ready), 1);
      end
      if (t == 2 * gap + 3) chk("a_ready_finish", int'(a_ready), 0);
      a_en     = hold && (t <= 2 * gap + 3);
      a_itable = ~it;
      a_valid  = (t == gap + 1) || (t == 2 * gap + 2);
      a_data   = (t == gap + 1) ? b0 : b1;
    end
    a_valid = 1'b0;
    chk("a_latency", lat, 2 * gap + 3);
    chk("a_idle_after", int'(a_busy), 0);
    chk("a_err_clear", int'(a_err), 0);
  endtask

  // Three-byte back-to-back sequence on B; lanes run 2,1,0.
  task automatic run_b(input logic [7:0] it, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input int sel, input int exp_err);
    int lat;
    lat = -1;
    wq1.push_back('{idx: 4'(1 << sel), lane: 4'd2, data: b0});
    wq1.push_back('{idx: 4'(1 << sel), lane: 4'd1, data: b1});
    wq1.push_back('{idx: 4'(1 << sel), lane: 4'd0, data: b2});
    eq1.push_back(exp_err);
    b_itable = it;
    b_en     = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      step();
      if (b_cm1 && lat < 0) lat = t;
      b_en    = 1'b0;
      b_valid = (t <= 3);
      b_data  = (t == 1) ? b0 : ((t == 2) ? b1 : b2);
    end
    b_valid = 1'b0;
    chk("b_latency", lat, 4);
    chk("b_idle_after", int'(b_busy), 0);
  endtask

  initial begin
    int lat;
    a_reset = 1'b1; a_en = 1'b0; a_itable = 8'h00; a_valid = 1'b0; a_data = 8'h00;
    b_reset = 1'b1; b_en = 1'b0; b_itable = 8'h00; b_valid = 1'b0; b_data = 8'h00;
    repeat (3) step();
    chk("a_rst_busy", int'(a_busy), 0);
    chk("a_rst_err", int'(a_err), 0);
    chk("a_rst_ophd", int'(a_ophd), 0);
    chk("a_rst_ready", int'(a_ready), 0);
    chk("a_rst_xpt", int'(a_xpt), 0);
    chk("a_rst_cm1", int'(a_cm1), 0);
    chk("a_rst_wr", int'(a_wr_idx), 0);
    chk("b_rst_busy", int'(b_busy), 0);
    chk("b_rst_err", int'(b_err), 0);
    a_reset = 1'b0;
    b_reset = 1'b0;
    step();

    run_a(8'h21, 8'h34, 8'h12, 0, 0, 1'b0);
    step();
    run_a(8'h25, 8'h56, 8'h78, 2, 1, 1'b0);
    step();

    // Abort after the first byte: its write stands, no end pulses follow.
    wq0.push_back('{idx: 4'd1, lane: 4'd0, data: 8'h9A});
    a_itable = 8'h21;
    a_en     = 1'b1;
    step();
    a_en = 1'b0; a_valid = 1'b1; a_data = 8'h9A;
    step();
    a_valid = 1'b0; a_reset = 1'b1;
    chk("a_busy_pre_abort", int'(a_busy), 1);
    step();
    a_reset = 1'b0;
    chk("a_abort_busy", int'(a_busy), 0);
    chk("a_abort_ophd", int'(a_ophd), 0);
    repeat (4) step();
    run_a(8'h21, 8'hC3, 8'h3C, 1, 0, 1'b0);
    step();
    run_a(8'h25, 8'hE1, 8'h1E, 0, 1, 1'b1);

    run_b(8'h21, 8'hAA, 8'hBB, 8'hCC, 0, 0);
    step();

    // Select field 3 on a 3-register file: error, straight to FINISH, no writes.
    eq1.push_back(1);
    lat      = -1;
    b_itable = 8'h2D;
    b_en     = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      step();
      if (b_cm1 && lat < 0) lat = t;
      if (t == 1) chk("b_err_ready", int'(b_ready), 0);
      b_en    = 1'b0;
      b_valid = 1'b1;
      b_data  = 8'hFF;
    end
    b_valid = 1'b0;
    chk("b_err_latency", lat, 1);
    chk("b_err_set", int'(b_err), 1);
    chk("b_err_busy", int'(b_busy), 0);
    step();
    run_b(8'h25, 8'h11, 8'h22, 8'h33, 1, 1);
    chk("b_err_sticky", int'(b_err), 1);
    b_reset = 1'b1;
    step();
    b_reset = 1'b0;
    chk("b_err_cleared", int'(b_err), 0);

    repeat (3) step();
    chk("a_queue_left", wq0.size() + eq0.size(), 0);
    chk("b_queue_left", wq1.size() + eq1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
